// File: rtl/rand_range_sampler.sv
// Draws uniform values in [0, limit) from an external LFSR by masked rejection
// sampling, refreshing the LFSR between attempts and falling back after MAX_TRIES.
module rand_range_sampler #(
    parameter int WIDTH     = 11,
    parameter int OUT_W     = 8,
    parameter int SHIFTS    = 11,
    parameter int MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lfsr_count,
    output logic             shift_enable,
    input  logic             req,
    input  logic [OUT_W-1:0] limit,
    output logic             busy,
    output logic             valid,
    input  logic             ready,
    output logic [OUT_W-1:0] value
);

    localparam int SC_W = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
    localparam int TC_W = $clog2(MAX_TRIES + 1);
    localparam logic [OUT_W-1:0] ONE = OUT_W'(1);
    localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(SHIFTS - 1);
    localparam logic [TC_W-1:0] TRY_LAST = TC_W'(MAX_TRIES - 1);

    // state | meaning
    // IDLE  | waiting for req; LFSR left untouched
    // SHIFT | refreshing the LFSR, SHIFTS cycles of shift_enable
    // CHECK | masking the LFSR value and accepting or rejecting it
    // DONE  | result presented with valid until handshake
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DONE} state_t;

    state_t           state, state_nxt;
    logic [OUT_W-1:0] lim, lim_nxt;
    logic [OUT_W-1:0] mask, mask_nxt;
    logic [OUT_W-1:0] value_nxt;
    logic [OUT_W-1:0] smear;
    logic [OUT_W-1:0] cand;
    logic [SC_W-1:0]  shift_cnt, shift_cnt_nxt;
    logic [TC_W-1:0]  try_cnt, try_cnt_nxt;

    generate
        if (WIDTH > OUT_W) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^lfsr_count[WIDTH-1:OUT_W];
        end
    endgenerate

    // Smear the highest set bit of limit-1 downward to get the smallest covering mask.
    always_comb begin
        smear = limit - ONE;
        for (int i = OUT_W - 2; i >= 0; i--) begin
            smear[i] = smear[i] | smear[i+1];
        end
    end

    assign cand = lfsr_count[OUT_W-1:0] & mask;

    always_comb begin
        state_nxt     = state;
        lim_nxt       = lim;
        mask_nxt      = mask;
        value_nxt     = value;
        shift_cnt_nxt = shift_cnt;
        try_cnt_nxt   = try_cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    lim_nxt     = limit;
                    mask_nxt    = smear;
                    try_cnt_nxt = '0;
                    if (limit == '0) begin
                        value_nxt = '0;
                        state_nxt = DONE;
                    end else begin
                        shift_cnt_nxt = '0;
                        state_nxt     = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (shift_cnt == SHIFT_LAST) begin
                    state_nxt = CHECK;
                end else begin
                    shift_cnt_nxt = shift_cnt + 1'b1;
                end
            end
            CHECK: begin
                if (cand < lim) begin
                    value_nxt = cand;
                    state_nxt = DONE;
                end else if (try_cnt == TRY_LAST) begin
                    // mask < 2*lim, so this difference is always below lim
                    value_nxt = cand - lim;
                    state_nxt = DONE;
                end else begin
                    try_cnt_nxt   = try_cnt + 1'b1;
                    shift_cnt_nxt = '0;
                    state_nxt     = SHIFT;
                end
            end
            DONE: begin
                if (ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lim       <= '0;
            mask      <= '0;
            value     <= '0;
            shift_cnt <= '0;
            try_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            lim       <= lim_nxt;
            mask      <= mask_nxt;
            value     <= value_nxt;
            shift_cnt <= shift_cnt_nxt;
            try_cnt   <= try_cnt_nxt;
        end
    end

    // Held high through reset so the LFSR loads its seed.
    assign shift_enable = rst | (state == SHIFT);
    assign busy         = (state != IDLE);
    assign valid        = (state == DONE);

endmodule

// File: tb/tb_rand_range_sampler.sv
// Directed bench for rand_range_sampler driving a behavioural 11-bit LFSR
// (x^11 + x^9 + 1) and checking results against a transaction-level model.
module tb_rand_range_sampler;

    localparam logic [10:0] SEED = 11'b01001011101;

    logic        clk;
    logic        rst;
    logic        req;
    logic        ready;
    logic [7:0]  limit;
    logic [10:0] lfsr_q;
    logic [10:0] force_val;
    logic        force_en;
    logic [10:0] lfsr_count;
    logic        shift_enable;
    logic        busy;
    logic        valid;
    logic [7:0]  value;

    int n_checks = 0;
    int n_fail   = 0;
    int sh_count = 0;

    logic [10:0] m_lfsr;

    rand_range_sampler #(
        .WIDTH(11), .OUT_W(8), .SHIFTS(11), .MAX_TRIES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lfsr_count(lfsr_count),
        .shift_enable(shift_enable),
        .req(req),
        .limit(limit),
        .busy(busy),
        .valid(valid),
        .ready(ready),
        .value(value)
    );

    function automatic logic [10:0] lstep(input logic [10:0] q);
        return {q[9:0], q[10] ^ q[8]};
    endfunction

    always @(posedge clk) begin
        if (shift_enable) lfsr_q <= rst ? SEED : lstep(lfsr_q);
    end

    always @(posedge clk) begin
        if (shift_enable && !rst) sh_count++;
    end

    assign lfsr_count = force_en ? force_val : lfsr_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Transaction model: advances m_lfsr exactly as the sampler should.
    task automatic model_draw(input logic [7:0] lim_in, output logic [7:0] v, output int tries);
        logic [7:0] m;
        logic [7:0] c;
        logic [7:0] lm1;
        m = '0;
        v = '0;
        tries = 0;
        if (lim_in == 8'd0) return;
        lm1 = lim_in - 8'd1;
        for (int b = 0; b < 8; b++) if ((lm1 >> b) != 8'd0) m[b] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            for (int s = 0; s < 11; s++) m_lfsr = lstep(m_lfsr);
            tries++;
            c = m_lfsr[7:0] & m;
            if (c < lim_in) begin
                v = c;
                return;
            end
            if (t == 3) v = c - lim_in;
        end
    endtask

    // Called at posedge+1 with the DUT idle; counts the accept edge as edge 1.
    task automatic draw(input logic [7:0] lim_in, output logic [7:0] v, output int lat, output int sh);
        req = 1'b1;
        limit = lim_in;
        sh_count = 0;
        @(posedge clk); #1;
        req = 1'b0;
        limit = 8'hAA;
        lat = 1;
        while (!valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check("draw_valid", valid, 1);
        v = value;
        sh = sh_count;
        if (ready) begin
            @(posedge clk); #1;
            check("handshake_drop", valid, 0);
        end
    endtask

    initial begin
        logic [7:0] v, e, t2_val;
        int lat, sh, tries;
        int hits[6];

        rst = 1'b1;
        req = 1'b0;
        ready = 1'b1;
        limit = 8'd0;
        force_en = 1'b0;
        force_val = 11'h0FF;
        for (int i = 0; i < 6; i++) hits[i] = 0;

        // T1 reset
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t1_shen_in_rst", shift_enable, 1);
        end
        check("t1_lfsr_seed", lfsr_q, SEED);
        rst = 1'b0;
        #1;
        check("t1_valid", valid, 0);
        check("t1_busy", busy, 0);
        check("t1_value", value, 0);
        check("t1_shen_idle", shift_enable, 0);
        m_lfsr = SEED;

        // T2 first-try draw from the seed
        model_draw(8'd16, e, tries);
        draw(8'd16, v, lat, sh);
        t2_val = e;
        check("t2_value", v, e);
        check("t2_tries", tries, 1);
        check("t2_latency", lat, 13);
        check("t2_shifts", sh, 11);

        // T3 forced LFSR, every attempt rejected
        force_en = 1'b1;
        draw(8'd200, v, lat, sh);
        check("t3_fallback_value", v, 55);
        check("t3_shifts", sh, 44);
        check("t3_latency", lat, 49);
        for (int i = 0; i < 44; i++) m_lfsr = lstep(m_lfsr);
        draw(8'd0, v, lat, sh);
        check("t3_zero_value", v, 0);
        check("t3_zero_latency", lat, 1);
        check("t3_zero_shifts", sh, 0);
        force_en = 1'b0;

        // T4 consumer stall in DONE
        ready = 1'b0;
        model_draw(8'd6, e, tries);
        draw(8'd6, v, lat, sh);
        check("t4_value", v, e);
        check("t4_shifts", sh, 11 * tries);
        for (int i = 0; i < 20; i++) begin
            req = (i % 2 == 0);
            limit = 8'd3;
            @(posedge clk); #1;
            check("t4_valid_held", valid, 1);
            check("t4_value_held", value, e);
            check("t4_shen_low", shift_enable, 0);
        end
        req = 1'b0;
        ready = 1'b1;
        @(posedge clk); #1;
        check("t4_valid_drop", valid, 0);
        check("t4_busy_drop", busy, 0);
        @(posedge clk); #1;
        check("t4_no_queued_req", busy, 0);

        // T5 reset in the 5th SHIFT cycle
        req = 1'b1;
        limit = 8'd16;
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        check("t5_in_shift", shift_enable, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_busy_after_rst", busy, 0);
        check("t5_valid_after_rst", valid, 0);
        rst = 1'b0;
        m_lfsr = SEED;
        model_draw(8'd16, e, tries);
        draw(8'd16, v, lat, sh);
        check("t5_value_model", v, e);
        check("t5_value_as_t2", v, t2_val);
        check("t5_latency", lat, 13);
        check("t5_shifts", sh, 11);

        // T6 back-to-back draws
        for (int n = 0; n < 1000; n++) begin
            model_draw(8'd6, e, tries);
            draw(8'd6, v, lat, sh);
            check("t6_value", v, e);
            check("t6_range", (v < 8'd6), 1);
            check("t6_shifts", sh, 11 * tries);
            if (v < 8'd6) hits[v]++;
        end
        for (int i = 0; i < 6; i++) check("t6_hit", (hits[i] > 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
